// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the byte-wide RAM word access initiator.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_BYTE: n = 3'd1;
      SIZE_HALF: n = 3'd2;
      default:   n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] lo);
    logic m;
    case (size)
      SIZE_BYTE: m = 1'b0;
      SIZE_HALF: m = lo[0];
      default:   m = (lo != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_word_access.sv
// Big-endian 32-bit load/store to byte-wide dual-port RAM sequencer.
// Define MEM_ACCESS_MISALIGN_ERR_EN to reject misaligned half/word requests.
module mem_word_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [7:0]            ram_din,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [7:0]            ram_dout
);

  state_t                state;
  logic [2:0]            nbytes;
  logic [2:0]            cnt;
  logic [DATA_WIDTH-1:0] wsh;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] wjust;
  logic [2:0]            nb_in;
  logic                  mis;

  assign req_ready = (state == IDLE) && !reset;
  assign nb_in = size_to_nbytes(req_size);
  // left-justify so the first byte to send is always the top lane
  assign wjust = req_wdata << (6'd32 - {nb_in, 3'b000});

`ifdef MEM_ACCESS_MISALIGN_ERR_EN
  logic err_q;
  assign mis = misaligned(req_size, req_addr[1:0]);
  assign resp_err = err_q;
`else
  assign mis = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      nbytes     <= 3'd0;
      cnt        <= 3'd0;
      wsh        <= '0;
      shreg      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      ram_waddr  <= '0;
      ram_din    <= 8'd0;
      ram_we     <= 1'b0;
      ram_raddr  <= '0;
`ifdef MEM_ACCESS_MISALIGN_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            nbytes <= nb_in;
            cnt    <= 3'd0;
            shreg  <= '0;
            if (mis) begin
              resp_valid <= 1'b1;
              resp_rdata <= '0;
`ifdef MEM_ACCESS_MISALIGN_ERR_EN
              err_q      <= 1'b1;
`endif
              state      <= RESP;
            end else if (req_we) begin
              ram_waddr <= req_addr;
              ram_din   <= wjust[DATA_WIDTH-1 -: 8];
              wsh       <= wjust << 8;
              ram_we    <= 1'b1;
              state     <= WRITE;
            end else begin
              ram_raddr <= req_addr;
              state     <= READ;
            end
          end
        end
        READ: begin
          cnt <= cnt + 3'd1;
          if (cnt + 3'd1 < nbytes)
            ram_raddr <= ram_raddr + 1'b1;
          // RAM data lags the issued address by one edge
          if (cnt != 3'd0)
            shreg <= {shreg[DATA_WIDTH-9:0], ram_dout};
          if (cnt == nbytes) begin
            resp_rdata <= {shreg[DATA_WIDTH-9:0], ram_dout};
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WRITE: begin
          if (cnt + 3'd1 < nbytes) begin
            cnt       <= cnt + 3'd1;
            ram_waddr <= ram_waddr + 1'b1;
            ram_din   <= wsh[DATA_WIDTH-1 -: 8];
            wsh       <= wsh << 8;
          end else begin
            ram_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            state      <= RESP;
          end
        end
        RESP: begin
`ifdef MEM_ACCESS_MISALIGN_ERR_EN
          err_q <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_word_access.sv
// Bench for mem_word_access with a behavioural byte RAM and response queue.
module tb_mem_word_access;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_din;
  logic          ram_we;
  logic [AW-1:0] ram_raddr;
  logic [7:0]    ram_dout;

  mem_word_access #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .ram_waddr(ram_waddr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [512];
  logic       init_mem = 1'b0;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'(i);
    end else if (ram_we) begin
      mem[ram_waddr] <= ram_din;
    end
    ram_dout <= mem[ram_raddr];
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwe;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   we_cnt = 0;
  bit   busy = 0;
  bit   ready_viol = 0;
  logic prev_rv = 1'b0;
  exp_t sb[$];
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (ram_we) we_cnt++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (busy && req_ready) ready_viol = 1;
    if (prev_rv) chk("resp_pulse_width", {31'd0, resp_valid}, 32'd0);
    if (resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected 0");
      end else begin
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
        chk("ram_we_cycles", 32'(we_cnt), 32'(e.nwe));
        chk("ready_low_busy", {31'd0, ready_viol}, 32'd0);
        busy = 0;
      end
    end
    prev_rv = resp_valid;
  end

  function automatic int nb_of(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit mis_of(input logic [1:0] s, input logic [8:0] a);
`ifdef MEM_ACCESS_MISALIGN_ERR_EN
    return (s == 2'd1) ? a[0] : (s == 2'd0) ? 1'b0 : (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_req(input vec_t v);
    exp_t e;
    int   k;
    int   n;
    bit   m;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = v.we;
    req_size  = v.size;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      chk("accept_timeout", 32'd1, 32'd0);
      req_valid = 1'b0;
      return;
    end
    n = nb_of(v.size);
    m = mis_of(v.size, v.addr);
    e.rdata = (m || v.we) ? 32'd0 : v.rdata;
    e.err   = m;
    e.lat   = m ? 0 : (v.we ? n : n + 1);
    e.nwe   = (v.we && !m) ? n : 0;
    we_cnt = 0;
    ready_viol = 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    busy = 1;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_size  = 2'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = $urandom;
    k = 0;
    while (busy && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      chk("resp_timeout", 32'd1, 32'd0);
      busy = 0;
      if (sb.size() != 0) void'(sb.pop_front());
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 2'd2, 9'h010, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 2'd2, 9'h010, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 2'd1, 9'h1FF, 32'hABCD1234, 32'h0};
    vecs[3]  = '{1'b0, 2'd1, 9'h1FF, 32'h0,        32'h00001234};
    vecs[4]  = '{1'b1, 2'd0, 9'h020, 32'hFFFFFF80, 32'h0};
    vecs[5]  = '{1'b0, 2'd0, 9'h020, 32'h0,        32'h00000080};
    vecs[6]  = '{1'b0, 2'd2, 9'h002, 32'h0,        32'h02030405};
    vecs[7]  = '{1'b0, 2'd2, 9'h1FE, 32'h0,        32'hFE123401};
    vecs[8]  = '{1'b1, 2'd3, 9'h030, 32'h11223344, 32'h0};
    vecs[9]  = '{1'b0, 2'd3, 9'h030, 32'h0,        32'h11223344};
    vecs[10] = '{1'b0, 2'd1, 9'h012, 32'h0,        32'h0000BEEF};
    vecs[11] = '{1'b0, 2'd0, 9'h013, 32'h0,        32'h000000EF};

    reset = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'd0;
    req_addr = '0;
    req_wdata = '0;
    init_mem = 1'b1;
    repeat (2) @(negedge clk);
    init_mem = 1'b0;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_we", {31'd0, ram_we}, 32'd0);
    chk("rst_waddr", 32'(ram_waddr), 32'd0);
    chk("rst_raddr", 32'(ram_raddr), 32'd0);
    chk("rst_din", 32'(ram_din), 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 12; i++) do_req(vecs[i]);

    chk("mem_010", 32'(mem[9'h010]), 32'hDE);
    chk("mem_011", 32'(mem[9'h011]), 32'hAD);
    chk("mem_012", 32'(mem[9'h012]), 32'hBE);
    chk("mem_013", 32'(mem[9'h013]), 32'hEF);
    chk("mem_020", 32'(mem[9'h020]), 32'h80);
    chk("mem_021_untouched", 32'(mem[9'h021]), 32'h21);
`ifdef MEM_ACCESS_MISALIGN_ERR_EN
    chk("mem_1ff_noerrwr", 32'(mem[9'h1FF]), 32'hFF);
    chk("mem_000_noerrwr", 32'(mem[9'h000]), 32'h00);
`else
    chk("mem_1ff_wrap", 32'(mem[9'h1FF]), 32'h12);
    chk("mem_000_wrap", 32'(mem[9'h000]), 32'h34);
`endif

    // reset lands after the second byte of a word store
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd2;
    req_addr  = 9'h040;
    req_wdata = 32'hA1B2C3D4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_we_before_rst", {31'd0, ram_we}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_we_async_drop", {31'd0, ram_we}, 32'd0);
    chk("mid_ready_in_rst", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_ready_after", {31'd0, req_ready}, 32'd1);
    chk("mid_mem_040", 32'(mem[9'h040]), 32'hA1);
    chk("mid_mem_041", 32'(mem[9'h041]), 32'hB2);
    chk("mid_mem_042", 32'(mem[9'h042]), 32'h42);
    chk("mid_mem_043", 32'(mem[9'h043]), 32'h43);
    do_req('{1'b0, 2'd2, 9'h040, 32'h0, 32'hA1B24243});

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
